// File: rtl/gray_cnt_if.sv
// ---------------------------------------------------------------------------
// gray_cnt_if
// Bundles the control inputs and count outputs of the Gray counter so that
// the counter and its driver can be hooked up with a single port.
//
//   en      count enable
//   dir     count direction, 1 = up, 0 = down
//   ld      parallel load strobe
//   ld_gry  Gray value to load (index 0 is MSB)
//   gry     registered Gray count (index 0 is MSB)
//   bn      registered binary count (index 0 is MSB)
//   tc      terminal count for the current direction
//   wrap    one-cycle pulse after a wrap-around edge
//
// master : whoever drives the controls (bench or upstream logic)
// slave  : the counter itself
// ---------------------------------------------------------------------------
interface gray_cnt_if #(
   parameter int WIDTH = 4
);

   logic             en;
   logic             dir;
   logic             ld;
   logic [0:WIDTH-1] ld_gry;
   logic [0:WIDTH-1] gry;
   logic [0:WIDTH-1] bn;
   logic             tc;
   logic             wrap;

   modport master (
      output en, dir, ld, ld_gry,
      input  gry, bn, tc, wrap
   );

   modport slave (
      input  en, dir, ld, ld_gry,
      output gry, bn, tc, wrap
   );

endinterface

// File: rtl/gray_cnt.sv
// ---------------------------------------------------------------------------
// gray_cnt
// Synchronous up/down counter whose primary output is the registered Gray
// code of its count. Feeds the Gray-to-binary converter downstream, so every
// count edge changes exactly one bit of gry (including across a wrap).
//
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset (clears count and wrap)
//   bus    gray_cnt_if.slave : en, dir, ld, ld_gry in; gry, bn, tc, wrap out
//
// Priority on each edge: reset > load > count > hold.
// All vectors use index 0 as the MSB.
//
// Optional build macro:
//   GRAY_CNT_SAT_EN  when defined the counter saturates at its terminal
//                    value instead of wrapping, and wrap is held at 0.
// ---------------------------------------------------------------------------
module gray_cnt #(
   parameter int WIDTH = 4
) (
   input logic       clk,
   input logic       rst_n,
   gray_cnt_if.slave bus
);

   localparam logic [0:WIDTH-1] unit = {{(WIDTH-1){1'b0}}, 1'b1};

   logic [0:WIDTH-1] bn_q;
   logic [0:WIDTH-1] gry_q;
   logic             wrap_q;

   logic [0:WIDTH-1] ld_bin;
   logic [0:WIDTH-1] nxt_bn;
   logic [0:WIDTH-1] nxt_gry;
   logic             nxt_wrap;
   logic             tc;

   // Decode the Gray load value to binary. Each binary bit is the running
   // XOR of all Gray bits from the MSB down to that position.
   always_comb begin
      ld_bin    = '0;
      ld_bin[0] = bus.ld_gry[0];
      for (int i = 1; i < WIDTH; i++) begin
         ld_bin[i] = ld_bin[i-1] ^ bus.ld_gry[i];
      end
   end

   // Terminal count depends on the live dir input so it reacts to a
   // direction change without waiting for an edge.
   always_comb begin
      tc = bus.dir ? (&bn_q) : ~(|bn_q);
   end

   // Next binary value and wrap flag. A count edge that starts on the
   // terminal value is the one that wraps (or, in saturating builds, holds).
   always_comb begin
      nxt_bn   = bn_q;
      nxt_wrap = 1'b0;
      if (bus.ld) begin
         nxt_bn = ld_bin;
      end else if (bus.en) begin
`ifdef GRAY_CNT_SAT_EN
         if (!tc) begin
            nxt_bn = bus.dir ? (bn_q + unit) : (bn_q - unit);
         end
`else
         nxt_bn   = bus.dir ? (bn_q + unit) : (bn_q - unit);
         nxt_wrap = tc;
`endif
      end
   end

   // Gray code of the next value, registered on the same edge as the binary
   // so the two outputs never disagree.
   always_comb begin
      nxt_gry    = '0;
      nxt_gry[0] = nxt_bn[0];
      for (int i = 1; i < WIDTH; i++) begin
         nxt_gry[i] = nxt_bn[i-1] ^ nxt_bn[i];
      end
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         bn_q   <= '0;
         gry_q  <= '0;
         wrap_q <= 1'b0;
      end else begin
         bn_q   <= nxt_bn;
         gry_q  <= nxt_gry;
         wrap_q <= nxt_wrap;
      end
   end

   assign bus.bn   = bn_q;
   assign bus.gry  = gry_q;
   assign bus.wrap = wrap_q;
   assign bus.tc   = tc;

endmodule
